noise_poly_sampler: RTL and testbench
=====================================

NOISE_POLY_SAMPLER -- requirements
Module: noise_poly_sampler

Interface
REQ-001 SHALL have parameter N, default 4, number of coefficients per polynomial.
REQ-002 SHALL have parameter Q, default 17, coefficient modulus.
REQ-003 SHALL have parameter ETA, default 1, accepted noise bound (samples in [-ETA, ETA]).
REQ-004 SHALL have parameter COEF_W, default 5, coefficient width; value SHALL be >= $clog2(Q).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, request one polynomial; honoured only in IDLE.
REQ-008 SHALL have port rng_enable, output, 1, drives the random number generator's enable.
REQ-009 SHALL have port rng_data, input, signed 32, generator's registered random_number.
REQ-010 SHALL have port busy, output, 1, high in COLLECT or HOLD.
REQ-011 SHALL have port poly_valid, output, 1, polynomial available.
REQ-012 SHALL have port poly_ready, input, 1, consumer accepts polynomial.
REQ-013 SHALL have port poly_data, output, N*COEF_W; coefficient i at [i*COEF_W +: COEF_W].
REQ-014 SHALL have port reject_count, output, 16, count of rejected samples.

Function
REQ-015 SHALL implement states IDLE, COLLECT, HOLD; start in IDLE -> COLLECT; count==N -> HOLD; poly_valid&&poly_ready in HOLD -> IDLE.
REQ-016 SHALL clear accepted count (0..N) on IDLE->COLLECT.
REQ-017 SHALL register pending <= rng_enable each cycle; rng_data is consumed only in a cycle where pending==1.
REQ-018 SHALL drive rng_enable = (state==COLLECT) && !(pending && count==N-1), combinationally from registered state.
REQ-019 SHALL accept consumed sample v iff -ETA <= v <= ETA (full 32-bit signed compare); coefficient = v<0 ? Q+v : v.
REQ-020 SHALL write accepted coefficient to slot index=count and increment count in the same edge.
REQ-021 SHALL discard out-of-range samples without changing count or poly_data, and increment reject_count, saturating at 0xFFFF.
REQ-022 SHALL, with no rejections, assert poly_valid N+1 cycles after the edge sampling start.
REQ-023 SHALL hold poly_valid=1 and poly_data stable in HOLD until poly_ready; poly_valid deasserts the cycle after handshake.
REQ-024 SHALL ignore start while busy; start and handshake in the same cycle SHALL not start a new collection (start re-sampled in IDLE).
REQ-025 SHALL never accept more than N coefficients; any pending sample arriving outside COLLECT SHALL be dropped uncounted.
REQ-026 SHALL keep poly_data unchanged in IDLE (last polynomial retained).

Reset
REQ-027 SHALL, on rst_n low at any time, asynchronously force state=IDLE, count=0, pending=0, rng_enable=0, busy=0, poly_valid=0, poly_data=0, reject_count=0.
REQ-028 SHALL abandon any partial polynomial on reset mid-COLLECT or mid-HOLD; no poly_valid until a new start completes.

Verification
REQ-029 Reset released, no start -> all outputs 0 indefinitely, rng_enable 0.
REQ-030 start pulse; rng_data sequence -1,0,1,1 (N=4,Q=17) -> poly_valid after 5 cycles, coefficients {16,0,1,1}, reject_count 0, exactly 4 rng_enable cycles.
REQ-031 start; rng_data 5,-17,1,-1,0,0 -> reject_count 2, coefficients {1,16,0,0}, poly_valid after 7 cycles.
REQ-032 poly_ready low 10 cycles in HOLD, then pulse -> poly_data and poly_valid stable throughout, IDLE next cycle; start during HOLD ignored.
REQ-033 rst_n low after 2 accepted coefficients -> outputs zeroed immediately; new start yields full fresh N-coefficient polynomial.
REQ-034 Force 70000 out-of-range samples -> reject_count saturates at 0xFFFF, no wrap.

Source files
------------

// File: rtl/noise_poly_sampler.sv
// Noise polynomial sampler: draws N small coefficients from a registered RNG,
// rejecting samples outside [-ETA, ETA], and offers the polynomial through a
// valid/ready handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; last polynomial retained on poly_data
// S_COLLECT | requesting RNG samples, accepting/rejecting into slots
// S_HOLD    | full polynomial offered, waiting for poly_ready
module noise_poly_sampler #(
   parameter int N      = 4,
   parameter int Q      = 17,
   parameter int ETA    = 1,
   parameter int COEF_W = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   rng_enable,
   input  logic signed [31:0]     rng_data,
   output logic                   busy,
   output logic                   poly_valid,
   input  logic                   poly_ready,
   output logic [N*COEF_W-1:0]    poly_data,
   output logic [15:0]            reject_count
);

   localparam int CNT_W = $clog2(N + 1);
   localparam logic signed [31:0] ETA_POS = 32'(ETA);
   localparam logic signed [31:0] ETA_NEG = 32'(-ETA);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_HOLD
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 pending_q;
   logic [N*COEF_W-1:0]  poly_q, poly_d;
   logic [15:0]          reject_q, reject_d;

   logic                 sample_ok;
   logic [COEF_W-1:0]    sample_coef;

   // Full-width signed range test; negative samples fold to Q+v.
   assign sample_ok   = (rng_data >= ETA_NEG) && (rng_data <= ETA_POS);
   assign sample_coef = rng_data[31] ? COEF_W'(rng_data + 32'(Q)) : COEF_W'(rng_data);

   // Stop requesting once the sample in flight could complete the polynomial,
   // so no sample beyond the Nth accepted one is ever drawn.
   assign rng_enable   = (state_q == S_COLLECT) &&
                         !(pending_q && (count_q == CNT_W'(N - 1)));
   assign busy         = (state_q != S_IDLE);
   assign poly_valid   = (state_q == S_HOLD);
   assign poly_data    = poly_q;
   assign reject_count = reject_q;

   // State, slot counter, request tracking, polynomial and reject counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         pending_q <= 1'b0;
         poly_q    <= '0;
         reject_q  <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pending_q <= rng_enable;
         poly_q    <= poly_d;
         reject_q  <= reject_d;
      end
   end

   // Next-state logic: start handling, sample acceptance and handshake.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      poly_d   = poly_q;
      reject_d = reject_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_COLLECT;
               count_d = '0;
            end
         end
         S_COLLECT: begin
            if (pending_q) begin
               if (sample_ok) begin
                  for (int i = 0; i < N; i++) begin
                     if (count_q == CNT_W'(i)) begin
                        poly_d[i*COEF_W +: COEF_W] = sample_coef;
                     end
                  end
                  count_d = count_q + CNT_W'(1);
                  if (count_q == CNT_W'(N - 1)) begin
                     state_d = S_HOLD;
                  end
               end else if (reject_q != 16'hFFFF) begin
                  reject_d = reject_q + 16'd1;
               end
            end
         end
         S_HOLD: begin
            if (poly_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_noise_poly_sampler.sv
// Directed bench for noise_poly_sampler with a registered RNG model and a
// scoreboard of expected polynomials.
module tb_noise_poly_sampler;

   localparam int N      = 4;
   localparam int Q      = 17;
   localparam int ETA    = 1;
   localparam int COEF_W = 5;
   localparam int PW     = N * COEF_W;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                poly_ready = 1'b0;
   logic                rng_enable;
   logic signed [31:0]  rng_data;
   logic                busy;
   logic                poly_valid;
   logic [PW-1:0]       poly_data;
   logic [15:0]         reject_count;

   int vectors = 0;
   int miscompares = 0;
   int exp_rej = 0;
   int en_cnt = 0;
   int gen_q[$];
   int vals[$];

   typedef struct {
      logic [PW-1:0] poly;
      int            rej;
      int            lat;
      int            nen;
   } exp_t;
   exp_t sb[$];

   noise_poly_sampler #(.N(N), .Q(Q), .ETA(ETA), .COEF_W(COEF_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .rng_enable   (rng_enable),
      .rng_data     (rng_data),
      .busy         (busy),
      .poly_valid   (poly_valid),
      .poly_ready   (poly_ready),
      .poly_data    (poly_data),
      .reject_count (reject_count)
   );

   always #5 clk = ~clk;

   // Registered RNG: new number appears after an edge where enable was high.
   // An empty queue yields an out-of-range value.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rng_data <= 32'sd0;
      end else if (rng_enable) begin
         en_cnt <= en_cnt + 1;
         if (gen_q.size() > 0) rng_data <= gen_q.pop_front();
         else                  rng_data <= 32'sd1000;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: first N in-range values fill slots in order; out-of-range
   // values seen before that are rejections.
   task automatic build_expect(input int lat);
      exp_t e;
      int acc = 0;
      int rej = 0;
      int used = 0;
      e.poly = '0;
      foreach (vals[i]) begin
         if (acc < N) begin
            used++;
            if (vals[i] >= -ETA && vals[i] <= ETA) begin
               e.poly[acc*COEF_W +: COEF_W] = COEF_W'(vals[i] < 0 ? Q + vals[i] : vals[i]);
               acc++;
            end else begin
               rej++;
            end
         end
         gen_q.push_back(vals[i]);
      end
      exp_rej = (exp_rej + rej > 65535) ? 65535 : exp_rej + rej;
      e.rej = exp_rej;
      e.lat = lat;
      e.nen = used;
      sb.push_back(e);
      vals.delete();
   endtask

   task automatic run_poly(input string tag, input int hold, input bit start_in_hold,
                           input bit start_with_hs);
      int   cyc = 0;
      int   base;
      exp_t e;
      base = en_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      while (!poly_valid && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      e = sb.pop_front();
      chk({tag, "_valid"}, 64'(poly_valid), 64'd1);
      if (e.lat >= 0) chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
      chk({tag, "_poly"}, 64'(poly_data), 64'(e.poly));
      chk({tag, "_rejects"}, 64'(reject_count), 64'(e.rej));
      for (int i = 0; i < hold; i++) begin
         start = (start_in_hold && i == 3);
         @(negedge clk);
         chk({tag, "_hold"}, 64'({poly_valid, busy, poly_data}), 64'({1'b1, 1'b1, e.poly}));
      end
      start = 1'b0;
      chk({tag, "_enables"}, 64'(en_cnt - base), 64'(e.nen));
      poly_ready = 1'b1;
      start = start_with_hs;
      @(negedge clk);
      poly_ready = 1'b0;
      start = 1'b0;
      chk({tag, "_after_hs"}, 64'({poly_valid, busy}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_idle"}, 64'({poly_valid, busy, rng_enable}), 64'd0);
      chk({tag, "_retained"}, 64'(poly_data), 64'(e.poly));
   endtask

   initial begin
      int v;
      int acc;
      repeat (3) @(negedge clk);
      chk("in_reset", 64'({rng_enable, busy, poly_valid, poly_data, reject_count}), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("idle_quiet", 64'({rng_enable, busy, poly_valid, poly_data, reject_count}), 64'd0);
      end

      // -1,0,1,1: no rejections, long hold with start ignored during HOLD
      vals = '{-1, 0, 1, 1};
      build_expect(N + 1);
      run_poly("A", 10, 1'b1, 1'b0);
      chk("A_coefs", 64'(poly_data), 64'({5'd1, 5'd1, 5'd0, 5'd16}));

      // 5,-17 rejected; start coincides with handshake
      vals = '{5, -17, 1, -1, 0, 0};
      build_expect(N + 3);
      run_poly("B", 0, 1'b0, 1'b1);
      chk("B_coefs", 64'(poly_data), 64'({5'd0, 5'd0, 5'd16, 5'd1}));
      chk("B_rejcount", 64'(reject_count), 64'd2);

      // Range boundaries and full 32-bit compare
      vals = '{2, -2, 32'sh8000_0000, 32'sh7FFF_FFFF, 0, 1, 32'sh0001_0001, -1, 1};
      build_expect(N + 6);
      run_poly("C", 2, 1'b0, 1'b0);

      // Reset after two accepted coefficients
      gen_q = '{0, 1, -1, 1};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset", 64'({rng_enable, busy, poly_valid, poly_data, reject_count}), 64'd0);
      gen_q.delete();
      exp_rej = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset", 64'({rng_enable, busy, poly_valid, poly_data}), 64'd0);
      vals = '{1, -1, 0, -1};
      build_expect(N + 1);
      run_poly("D", 1, 1'b0, 1'b0);

      // Random mixes of in-range and out-of-range samples
      for (int p = 0; p < 3; p++) begin
         acc = 0;
         while (acc < N) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom);
            else                           v = int'($urandom_range(0, 2)) - 1;
            if (v >= -ETA && v <= ETA) acc++;
            vals.push_back(v);
         end
         build_expect(-1);
         run_poly("R", 1, 1'b0, 1'b0);
      end

      // Saturation of the reject counter
      gen_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (70000) @(negedge clk);
      chk("sat_count", 64'(reject_count), 64'hFFFF);
      chk("sat_state", 64'({busy, poly_valid}), 64'b10);
      rst_n = 1'b0;
      @(negedge clk);
      chk("sat_reset", 64'(reject_count), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
